// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: data/byte-enable widths, FSM states,
// RV32I funct3 width codes and the access-legality check.
// Build option: LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses.
package load_store_unit_pkg;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  byte_en_t;
  typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 1 when the access may go to the bus; 0 means reject with err.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic ok;
    if (is_store) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else          ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
`ifdef LSU_MISALIGN_TRAP_EN
    if (((f3 == F3_H) || (f3 == F3_HU)) && a[0]) ok = 1'b0;
    if ((f3 == F3_W) && (a != 2'b00))            ok = 1'b0;
`else
    if (a == 2'b11) ok = ok;  // alignment bits are ignored in this build
`endif
    return ok;
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus: master = load/store unit, slave = memory.
interface load_store_unit_if;
  import load_store_unit_pkg::*;
  logic     mem_req;
  logic     mem_we;
  data_t    mem_addr;
  byte_en_t mem_be;
  data_t    mem_wdata;
  logic     mem_ready;
  data_t    mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// and extraction plus sign/zero extension of load data.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_addr_lo,
  input  data_t      i_store_data,
  input  data_t      i_rdata,
  output byte_en_t   o_be,
  output data_t      o_wdata,
  output data_t      o_load_val
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store side: width is funct3[1:0]; halfwords look at addr[1] only.
  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_store_data;
    case (i_funct3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_store_data[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: pick the lane, then extend by funct3.
  always_comb begin
    w_byte     = i_rdata[8*i_addr_lo +: 8];
    w_half     = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_load_val = i_rdata;
    case (i_funct3)
      F3_B:    o_load_val = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_val = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_val = {24'd0, w_byte};
      F3_HU:   o_load_val = {16'd0, w_half};
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store stage: one handshaked data-memory access per start,
// completion signalled by a done/err pulse. Build option LSU_MISALIGN_TRAP_EN
// (see package) turns misaligned halfword/word accesses into rejections.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_is_store,
  input  logic [2:0] i_funct3,
  input  data_t      i_addr,
  input  data_t      i_store_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output data_t      o_load_data,
  load_store_unit_if.master mem
);
  lsu_state_t r_state;
  logic       r_is_store;
  logic [2:0] r_funct3;
  data_t      r_addr;
  data_t      r_store_data;
  logic       r_err;
  data_t      r_load_data;
  byte_en_t   w_be;
  data_t      w_wdata;
  data_t      w_load_val;
  logic       w_req;

  lsu_lane_align u_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_store_data (r_store_data),
    .i_rdata      (mem.mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_val   (w_load_val)
  );

  // Control FSM and all captured request/response state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= '0;
      r_store_data <= '0;
      r_err        <= 1'b0;
      r_load_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_is_store   <= i_is_store;
          r_funct3     <= i_funct3;
          r_addr       <= i_addr;
          r_store_data <= i_store_data;
          if (access_ok(i_is_store, i_funct3, i_addr[1:0])) begin
            r_err   <= 1'b0;
            r_state <= REQ;
          end else begin
            r_err   <= 1'b1;
            r_state <= DONE;
            if (!i_is_store) r_load_data <= '0;
          end
        end
        REQ: if (mem.mem_ready) begin
          if (!r_is_store) r_load_data <= w_load_val;
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bus outputs come straight from captured registers, so they hold while
  // waiting; they are zeroed outside REQ and drop with an async reset.
  assign w_req         = (r_state == REQ);
  assign mem.mem_req   = w_req;
  assign mem.mem_we    = w_req & r_is_store;
  assign mem.mem_addr  = w_req ? {r_addr[31:2], 2'b00} : '0;
  assign mem.mem_be    = w_req ? w_be : '0;
  assign mem.mem_wdata = (w_req & r_is_store) ? w_wdata : '0;

  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE);
  assign o_err       = (r_state == DONE) & r_err;
  assign o_load_data = r_load_data;
endmodule
